cruise_cmd_seq: RTL and testbench
=================================

CRUISE_CMD_SEQ -- requirements
Module: cruise_cmd_seq

Interface
REQ-001 Parameters SHALL be, one per line:
- MIN_SPEED, 46, lowest speed at which engage, set or resume is honoured.
- REPEAT_DLY, 8, cycles from press to first auto-repeat pulse.
- REPEAT_PER, 4, cycles between subsequent auto-repeat pulses.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- btn_set, btn_accel, btn_coast, btn_cancel, btn_resume  in  1 each  driver button levels, already synchronous to clk.
- brake  in  1  brake pedal level.
- speed  in  8  current vehicle speed, unsigned mph.
- cmd_set, cmd_accel, cmd_coast, cmd_cancel, cmd_resume  out  1 each  registered one-cycle command pulses to the cruise datapath.
- state  out  2  current FSM state encoding.
- engaged  out  1  high when state == ENGAGED.

Function
REQ-003 States SHALL be IDLE (2'd0, no setpoint), ENGAGED (2'd1) and SUSPENDED (2'd2, setpoint retained, not regulating); 2'd3 is illegal and SHALL recover to IDLE on the next edge.
REQ-004 A press SHALL be a button that is high at edge k and was low at edge k-1; the resulting cmd_* SHALL be high from edge k to edge k+1 (one cycle).
REQ-005 At most one cmd_* SHALL be high in any cycle. Priority: brake > cancel > set > resume > accel/coast.
REQ-006 "Speed OK" SHALL mean unsigned speed >= MIN_SPEED with brake low.
REQ-007 IDLE: set press with speed OK -> cmd_set, go to ENGAGED. All other buttons SHALL be ignored.
REQ-008 ENGAGED:
- brake high, or cancel press -> cmd_cancel, go to SUSPENDED.
- set press with speed OK -> cmd_set, stay in ENGAGED.
- accel press -> cmd_accel; coast press -> cmd_coast.
REQ-009 SUSPENDED:
- resume press or set press with speed OK -> cmd_resume or cmd_set respectively, go to ENGAGED.
- accel, coast and cancel SHALL be ignored.
REQ-010 Brake held continuously SHALL produce only one cmd_cancel, on the edge the state leaves ENGAGED.
REQ-011 Auto-repeat: while accel (or coast) is held continuously in ENGAGED with no higher-priority event, pulses SHALL occur at press edge k, at k+REPEAT_DLY, and then every REPEAT_PER cycles.
REQ-012 The repeat counter SHALL clear on release, on any higher-priority event, and on leaving ENGAGED.
REQ-013 If accel and coast are both high, neither SHALL pulse and the repeat counter SHALL clear. Releasing one SHALL NOT create a press of the other unless that other shows a fresh low-to-high edge.
REQ-014 Repeat counter width SHALL be sized for max(REPEAT_DLY, REPEAT_PER) and SHALL saturate, never wrap.

Reset
REQ-015 While reset is low: state = IDLE, engaged = 0, all cmd_* = 0, repeat counter = 0.
REQ-016 During reset, previous-button registers SHALL be set to 1, so a button held through reset release is not a press.
REQ-017 Reset asserted mid-pulse or mid-repeat SHALL clear the outputs immediately (asynchronously). No command SHALL be issued on the first edge after release.

Structure
REQ-018 Package cruise_pkg SHALL hold the state typedef/encodings and the MIN_SPEED, REPEAT_DLY and REPEAT_PER defaults.
REQ-019 One sub-module, cc_repeat_timer, SHALL implement press detection and auto-repeat for a single button. It SHALL be instantiated for accel and for coast.
REQ-020 Target RTL size: 150-300 lines in total.

Verification
REQ-021 Reset release with btn_set held and speed = 60 -> no cmd_set; state stays IDLE until btn_set goes low then high.
REQ-022 IDLE, speed = 45, set press -> no pulse, state IDLE. Speed = 46, set press -> cmd_set for 1 cycle, state ENGAGED.
REQ-023 ENGAGED, btn_accel held 20 cycles from edge 0 -> cmd_accel at edges 0, 8, 12, 16 only.
REQ-024 ENGAGED, cancel, set and accel pressed on the same edge -> only cmd_cancel; next state SUSPENDED.
REQ-025 SUSPENDED, brake high with resume press at speed = 70 -> no pulse. Brake low, then resume press -> cmd_resume; state ENGAGED.
REQ-026 ENGAGED, brake held 10 cycles -> exactly one cmd_cancel; state SUSPENDED; reset pulsed low mid-sequence -> state IDLE and all outputs 0.

Source files
------------

// File: rtl/cruise_pkg.sv
// cruise_pkg -- shared definitions for the cruise-control command sequencer.
// Holds the FSM state encoding, the one-hot command codes and the default
// values for the MIN_SPEED, REPEAT_DLY and REPEAT_PER parameters.
package cruise_pkg;

  // FSM states; 2'd3 is unused and is steered back to IDLE by the sequencer.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ENGAGED   = 2'd1,
    ST_SUSPENDED = 2'd2
  } cc_state_e;

  localparam int unsigned CC_MIN_SPEED  = 32'd46;
  localparam int unsigned CC_REPEAT_DLY = 32'd8;
  localparam int unsigned CC_REPEAT_PER = 32'd4;

  // Command vector layout: {set, accel, coast, cancel, resume}.
  localparam logic [4:0] CMD_NONE   = 5'b00000;
  localparam logic [4:0] CMD_SET    = 5'b10000;
  localparam logic [4:0] CMD_ACCEL  = 5'b01000;
  localparam logic [4:0] CMD_COAST  = 5'b00100;
  localparam logic [4:0] CMD_CANCEL = 5'b00010;
  localparam logic [4:0] CMD_RESUME = 5'b00001;

  // Larger of two unsigned values; used to size the repeat counter.
  function automatic int unsigned cc_max(input int unsigned a, input int unsigned b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/cc_repeat_timer.sv
// cc_repeat_timer -- press detection and auto-repeat for one held button.
// fire is combinational from the internal registers and the inputs; the
// parent registers it into a command pulse.
// Ports:
//   clk    : clock
//   reset  : asynchronous active-low reset
//   btn    : button level, synchronous to clk
//   enable : repeat allowed this cycle; low clears the counter
//   fire   : request a pulse on this edge (press or repeat point)
module cc_repeat_timer
  import cruise_pkg::*;
#(
  parameter int unsigned REPEAT_DLY = CC_REPEAT_DLY,
  parameter int unsigned REPEAT_PER = CC_REPEAT_PER
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic enable,
  output logic fire
);

  localparam int unsigned CNT_MAX = cc_max(REPEAT_DLY, REPEAT_PER);
  localparam int unsigned CW      = $clog2(CNT_MAX + 32'd1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
  localparam logic [CW-1:0] DLY_L   = CW'(REPEAT_DLY);
  localparam logic [CW-1:0] PER_L   = CW'(REPEAT_PER);

  logic          prev_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          first_r;
  logic          first_nxt_s;
  logic          fire_s;
  logic          press_s;

  assign press_s = btn & ~prev_r;
  assign fire    = fire_s;

  // Counter value 0 means "not timing"; after a press it counts cycles since
  // the last pulse, comparing against the initial delay first, then the period.
  always_comb begin
    fire_s      = 1'b0;
    cnt_nxt_s   = cnt_r;
    first_nxt_s = first_r;
    if (!enable || !btn) begin
      cnt_nxt_s   = '0;
      first_nxt_s = 1'b0;
    end else if (press_s) begin
      fire_s      = 1'b1;
      cnt_nxt_s   = CNT_ONE;
      first_nxt_s = 1'b1;
    end else if (cnt_r != '0) begin
      if (cnt_r == (first_r ? DLY_L : PER_L)) begin
        fire_s      = 1'b1;
        cnt_nxt_s   = CNT_ONE;
        first_nxt_s = 1'b0;
      end else if (cnt_r < CNT_TOP) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      cnt_nxt_s = '0;
    end
  end

  // Previous-level register (preset to 1 so a button held through reset is
  // not a press) and repeat counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r  <= 1'b1;
      cnt_r   <= '0;
      first_r <= 1'b0;
    end else begin
      prev_r  <= btn;
      cnt_r   <= cnt_nxt_s;
      first_r <= first_nxt_s;
    end
  end

endmodule

// File: rtl/cruise_cmd_seq.sv
// cruise_cmd_seq -- turns driver button presses into one-cycle cruise
// commands and tracks IDLE / ENGAGED / SUSPENDED.
// Ports:
//   clk, reset (async active-low)
//   btn_set/accel/coast/cancel/resume : button levels
//   brake : brake pedal level;  speed : vehicle speed, unsigned mph
//   cmd_* : registered one-cycle command pulses (at most one high)
//   state : FSM state;  engaged : state == ENGAGED
module cruise_cmd_seq
  import cruise_pkg::*;
#(
  parameter int unsigned MIN_SPEED  = CC_MIN_SPEED,
  parameter int unsigned REPEAT_DLY = CC_REPEAT_DLY,
  parameter int unsigned REPEAT_PER = CC_REPEAT_PER
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set,
  input  logic       btn_accel,
  input  logic       btn_coast,
  input  logic       btn_cancel,
  input  logic       btn_resume,
  input  logic       brake,
  input  logic [7:0] speed,
  output logic       cmd_set,
  output logic       cmd_accel,
  output logic       cmd_coast,
  output logic       cmd_cancel,
  output logic       cmd_resume,
  output logic [1:0] state,
  output logic       engaged
);

  localparam logic [7:0] MIN_SPEED_L = 8'(MIN_SPEED);

  cc_state_e  state_r;
  cc_state_e  state_nxt_s;
  logic [4:0] cmd_r;
  logic [4:0] cmd_nxt_s;
  logic       engaged_r;
  logic [2:0] prev_r;        // {set, cancel, resume}
  logic       set_press_s;
  logic       cancel_press_s;
  logic       resume_press_s;
  logic       speed_ok_s;
  logic       hp_event_s;
  logic       rpt_en_s;
  logic       accel_fire_s;
  logic       coast_fire_s;

  assign set_press_s    = btn_set    & ~prev_r[2];
  assign cancel_press_s = btn_cancel & ~prev_r[1];
  assign resume_press_s = btn_resume & ~prev_r[0];
  assign speed_ok_s     = (speed >= MIN_SPEED_L) & ~brake;

  // Anything that outranks accel/coast while engaged stops the repeat.
  assign hp_event_s = brake | cancel_press_s | (set_press_s & speed_ok_s);
  assign rpt_en_s   = (state_r == ST_ENGAGED) & ~hp_event_s & ~(btn_accel & btn_coast);

  cc_repeat_timer #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_accel_rpt (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_accel),
    .enable (rpt_en_s),
    .fire   (accel_fire_s)
  );

  cc_repeat_timer #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_coast_rpt (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_coast),
    .enable (rpt_en_s),
    .fire   (coast_fire_s)
  );

  // Next-state and command decode in priority order brake > cancel > set >
  // resume > accel/coast.
  always_comb begin
    state_nxt_s = state_r;
    cmd_nxt_s   = CMD_NONE;
    case (state_r)
      ST_IDLE: begin
        if (set_press_s && speed_ok_s) begin
          cmd_nxt_s   = CMD_SET;
          state_nxt_s = ST_ENGAGED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ENGAGED: begin
        if (brake || cancel_press_s) begin
          cmd_nxt_s   = CMD_CANCEL;
          state_nxt_s = ST_SUSPENDED;
        end else if (set_press_s && speed_ok_s) begin
          cmd_nxt_s = CMD_SET;
        end else if (accel_fire_s) begin
          cmd_nxt_s = CMD_ACCEL;
        end else if (coast_fire_s) begin
          cmd_nxt_s = CMD_COAST;
        end else begin
          cmd_nxt_s = CMD_NONE;
        end
      end
      ST_SUSPENDED: begin
        if (set_press_s && speed_ok_s) begin
          cmd_nxt_s   = CMD_SET;
          state_nxt_s = ST_ENGAGED;
        end else if (resume_press_s && speed_ok_s) begin
          cmd_nxt_s   = CMD_RESUME;
          state_nxt_s = ST_ENGAGED;
        end else begin
          state_nxt_s = ST_SUSPENDED;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cmd_nxt_s   = CMD_NONE;
      end
    endcase
  end

  // FSM state and registered command / engaged outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cmd_r     <= CMD_NONE;
      engaged_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cmd_r     <= cmd_nxt_s;
      engaged_r <= (state_nxt_s == ST_ENGAGED);
    end
  end

  // Previous button levels, preset high so a button held through reset
  // release does not count as a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r <= 3'b111;
    end else begin
      prev_r <= {btn_set, btn_cancel, btn_resume};
    end
  end

  assign {cmd_set, cmd_accel, cmd_coast, cmd_cancel, cmd_resume} = cmd_r;
  assign state   = state_r;
  assign engaged = engaged_r;

endmodule

// File: tb/tb_cruise_cmd_seq.sv
module tb_cruise_cmd_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_set, btn_accel, btn_coast, btn_cancel, btn_resume, brake;
  logic [7:0] speed;
  logic       cmd_set, cmd_accel, cmd_coast, cmd_cancel, cmd_resume;
  logic [1:0] state;
  logic       engaged;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [4:0] N = 5'b00000;
  localparam logic [4:0] S = 5'b10000;
  localparam logic [4:0] A = 5'b01000;
  localparam logic [4:0] C = 5'b00100;
  localparam logic [4:0] X = 5'b00010;
  localparam logic [4:0] R = 5'b00001;
  localparam logic [1:0] IDL = 2'd0;
  localparam logic [1:0] ENG = 2'd1;
  localparam logic [1:0] SUS = 2'd2;

  // btns = {set, accel, coast, cancel, resume}
  typedef struct {
    logic [4:0] btns;
    logic       brk;
    logic [7:0] spd;
    logic [4:0] exp_cmd;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vq[$];

  cruise_cmd_seq dut (
    .clk(clk), .reset(reset),
    .btn_set(btn_set), .btn_accel(btn_accel), .btn_coast(btn_coast),
    .btn_cancel(btn_cancel), .btn_resume(btn_resume),
    .brake(brake), .speed(speed),
    .cmd_set(cmd_set), .cmd_accel(cmd_accel), .cmd_coast(cmd_coast),
    .cmd_cancel(cmd_cancel), .cmd_resume(cmd_resume),
    .state(state), .engaged(engaged)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] b, input logic br, input logic [7:0] sp,
                              input logic [4:0] ec, input logic [1:0] es);
    vec_t v;
    v.btns = b; v.brk = br; v.spd = sp; v.exp_cmd = ec; v.exp_st = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [4:0] ec, input logic [1:0] es);
    logic [7:0] act, exp;
    act = {cmd_set, cmd_accel, cmd_coast, cmd_cancel, cmd_resume, state, engaged};
    exp = {ec, es, (es == ENG)};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got cmd/state/eng=%b expected %b", name, act, exp);
  endtask

  task automatic drive(input logic [4:0] b, input logic br, input logic [7:0] sp);
    {btn_set, btn_accel, btn_coast, btn_cancel, btn_resume} = b;
    brake = br;
    speed = sp;
  endtask

  // Drive inputs, take one edge, sample 1 time unit later.
  task automatic step(input string name, input logic [4:0] b, input logic br,
                      input logic [7:0] sp, input logic [4:0] ec, input logic [1:0] es);
    drive(b, br, sp);
    @(posedge clk);
    #1;
    check(name, ec, es);
  endtask

  initial begin
    reset = 1'b0;
    drive(S, 1'b0, 8'd60);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", N, IDL);
    reset = 1'b1;

    // Table: set held through reset, speed threshold, engaged commands,
    // simultaneous presses, suspended behaviour, resume.
    vq.push_back(mk(S,      1'b0, 8'd60, N, IDL)); // 0 held through reset
    vq.push_back(mk(S,      1'b0, 8'd60, N, IDL)); // 1
    vq.push_back(mk(N,      1'b0, 8'd60, N, IDL)); // 2
    vq.push_back(mk(S,      1'b0, 8'd45, N, IDL)); // 3 below MIN_SPEED
    vq.push_back(mk(N,      1'b0, 8'd46, N, IDL)); // 4
    vq.push_back(mk(S,      1'b0, 8'd46, S, ENG)); // 5 at MIN_SPEED
    vq.push_back(mk(S,      1'b0, 8'd46, N, ENG)); // 6 held, no repeat of set
    vq.push_back(mk(N,      1'b0, 8'd46, N, ENG)); // 7
    vq.push_back(mk(S,      1'b0, 8'd46, S, ENG)); // 8 set while engaged
    vq.push_back(mk(A,      1'b0, 8'd50, A, ENG)); // 9 accel press
    vq.push_back(mk(C,      1'b0, 8'd50, C, ENG)); // 10 coast press
    vq.push_back(mk(A|C,    1'b0, 8'd50, N, ENG)); // 11 both high
    vq.push_back(mk(C,      1'b0, 8'd50, N, ENG)); // 12 release accel, coast not fresh
    vq.push_back(mk(N,      1'b0, 8'd50, N, ENG)); // 13
    vq.push_back(mk(X|S|A,  1'b0, 8'd50, X, SUS)); // 14 cancel wins
    vq.push_back(mk(N,      1'b0, 8'd50, N, SUS)); // 15
    vq.push_back(mk(A,      1'b0, 8'd50, N, SUS)); // 16 accel ignored
    vq.push_back(mk(X,      1'b0, 8'd50, N, SUS)); // 17 cancel ignored
    vq.push_back(mk(N,      1'b0, 8'd50, N, SUS)); // 18
    vq.push_back(mk(R,      1'b1, 8'd70, N, SUS)); // 19 resume with brake
    vq.push_back(mk(N,      1'b0, 8'd70, N, SUS)); // 20
    vq.push_back(mk(R,      1'b0, 8'd70, R, ENG)); // 21 resume
    vq.push_back(mk(N,      1'b0, 8'd70, N, ENG)); // 22
    vq.push_back(mk(R,      1'b0, 8'd70, N, ENG)); // 23 resume ignored when engaged
    vq.push_back(mk(N,      1'b0, 8'd70, N, ENG)); // 24

    for (int i = 0; i < vq.size(); i++) begin
      step($sformatf("vec%0d", i), vq[i].btns, vq[i].brk, vq[i].spd, vq[i].exp_cmd, vq[i].exp_st);
    end

    // Accel held 20 cycles: pulses at 0, 8, 12, 16.
    for (int i = 0; i < 20; i++) begin
      step($sformatf("accel_hold%0d", i), A, 1'b0, 8'd70,
           (i == 0 || i == 8 || i == 12 || i == 16) ? A : N, ENG);
    end
    step("accel_release", N, 1'b0, 8'd70, N, ENG);

    // Brake held 10 cycles: exactly one cancel.
    for (int i = 0; i < 10; i++) begin
      step($sformatf("brake_hold%0d", i), N, 1'b1, 8'd70, (i == 0) ? X : N, SUS);
    end

    // Reset pulsed mid brake sequence clears state asynchronously.
    #1 reset = 1'b0;
    #1 check("reset_mid_brake", N, IDL);
    #1 reset = 1'b1;
    step("post_reset_idle", N, 1'b0, 8'd60, N, IDL);

    // Reset asserted while cmd_set is high clears it at once.
    step("engage_again", S, 1'b0, 8'd60, S, ENG);
    #1 reset = 1'b0;
    #1 check("reset_mid_pulse", N, IDL);
    #1 reset = 1'b1;
    step("first_edge_after_release", S, 1'b0, 8'd60, N, IDL);
    step("set_low", N, 1'b0, 8'd60, N, IDL);
    step("set_fresh", S, 1'b0, 8'd60, S, ENG);

    // Reset mid auto-repeat, accel held through release is not a press.
    step("accel_press2", A, 1'b0, 8'd60, A, ENG);
    for (int i = 1; i < 9; i++) begin
      step($sformatf("accel2_%0d", i), A, 1'b0, 8'd60, (i == 8) ? A : N, ENG);
    end
    #1 reset = 1'b0;
    #1 check("reset_mid_repeat", N, IDL);
    #1 reset = 1'b1;
    step("accel_after_reset", A, 1'b0, 8'd60, N, IDL);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
